instr_prefetch_master: RTL and testbench
========================================

INSTR_PREFETCH_MASTER -- requirements
Module: instr_prefetch_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, byte-address width of the instruction memory port (MSB set = boot ROM region).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, instruction word width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, number of prefetch buffer entries (power of two, >= 2).
REQ-004 SHALL have parameter BOOT_ADDR, default 16'h8000, first fetch address after reset.
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 fetch_enable_i  input  1  fetching permitted when high.
REQ-008 branch_i  input  1  single-cycle redirect strobe.
REQ-009 branch_addr_i  input  ADDR_WIDTH  redirect target; bits [1:0] ignored.
REQ-010 ready_i  input  1  consumer accepts the head word this cycle.
REQ-011 valid_o  output  1  head entry valid.
REQ-012 instr_o  output  DATA_WIDTH  head instruction word.
REQ-013 pc_o  output  ADDR_WIDTH  byte address of instr_o.
REQ-014 mem_en_o  output  1  memory read request.
REQ-015 mem_addr_o  output  ADDR_WIDTH  word-aligned request address.
REQ-016 mem_we_o  output  1  constant 0.
REQ-017 mem_be_o  output  DATA_WIDTH/8  constant all ones.
REQ-018 mem_rdata_i  input  DATA_WIDTH  read data, valid exactly one cycle after mem_en_o.

Function
REQ-019 FSM states: IDLE (no requests), RUN (requesting); IDLE->RUN when fetch_enable_i=1, RUN->IDLE when fetch_enable_i=0; in-flight response still captured on that transition.
REQ-020 In RUN, mem_en_o SHALL be 1 when occupancy + in-flight (0/1) - pop_this_cycle < FIFO_DEPTH, else 0.
REQ-021 fetch_addr SHALL advance by 4 on each issued request, wrapping modulo 2^ADDR_WIDTH.
REQ-022 One-cycle pipeline register SHALL hold {pending, pc} of the issued request; on the following cycle mem_rdata_i with that pc SHALL be pushed unless discarded.
REQ-023 valid_o SHALL be 1 iff FIFO non-empty; pop on valid_o & ready_i; instr_o/pc_o undefined (don't-care) when valid_o=0.
REQ-024 Push and pop in the same cycle SHALL both occur; occupancy unchanged.
REQ-025 No bypass: a word pushed in cycle N is visible on valid_o in cycle N+1.
REQ-026 On branch_i: FIFO flushed; in-flight response discarded; if RUN, mem_en_o=1 with mem_addr_o={branch_addr_i[ADDR_WIDTH-1:2],2'b00} in the same cycle, fetch_addr becomes target+4; if IDLE, fetch_addr becomes target.
REQ-027 branch_i SHALL take priority over ready_i and over any simultaneous push.
REQ-028 valid_o SHALL be 0 in the cycle after branch_i; first post-branch word valid no earlier than 2 cycles after branch_i.
REQ-029 Full FIFO with ready_i=0 SHALL hold contents and issue no request.

Reset
REQ-030 On rst_n=0: state IDLE, fetch_addr=BOOT_ADDR, FIFO empty, pending=0; valid_o=0, mem_en_o=0, instr_o=0, pc_o=0.
REQ-031 Reset mid-operation SHALL drop any in-flight response; no push occurs in the first cycle after release.

Structure
REQ-032 BOOT_ADDR default and FIFO_DEPTH default SHALL live in the shared RISCV_MCU_CONFIG package.
REQ-033 The buffer SHALL be a sub-module prefetch_fifo (push, pop, flush, full, empty, count), holding {pc, instr}.

Verification
REQ-034 Reset release, fetch_enable_i=1, ready_i=1, memory returns addr-tagged data -> requests 0x8000,0x8004,...; pc_o sequence 0x8000,0x8004,... one word per cycle after 2-cycle startup.
REQ-035 ready_i=0 from start -> exactly 4 requests issued, mem_en_o=0 thereafter, valid_o=1 holding pc_o=0x8000.
REQ-036 branch_i with branch_addr_i=0x0103 while FIFO holds 3 entries and one in flight -> mem_addr_o=0x0100 same cycle, valid_o=0 next cycle, next pc_o=0x0100, stale words never appear.
REQ-037 fetch_addr at 0xFFFC -> next request 0x0000.
REQ-038 Full FIFO, ready_i=1 one cycle -> one pop, one new request same cycle, occupancy back to 4 after response.
REQ-039 rst_n asserted with request in flight -> after release valid_o=0, first request 0x8000.

Source files
------------

// File: rtl/riscv_mcu_config_pkg.sv
// Shared MCU configuration: boot vector, prefetch depth and fetch FSM states.
package riscv_mcu_config_pkg;

  localparam int unsigned CFG_FIFO_DEPTH = 4;
  localparam logic [15:0] CFG_BOOT_ADDR  = 16'h8000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/prefetch_fifo.sv
// Prefetch buffer holding {pc, instr} entries; flush empties it in one cycle.
module prefetch_fifo #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_pop;

  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  assign do_pop = pop & ~empty;
  assign rdata  = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      mem    <= '{default: '0};
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push != do_pop) begin
        count <= push ? count + 1'b1 : count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/instr_prefetch_master.sv
// Instruction prefetcher: streams sequential words from memory into a small
// buffer, with single-cycle branch redirect and credit-style request throttling.
module instr_prefetch_master
  import riscv_mcu_config_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           FIFO_DEPTH = CFG_FIFO_DEPTH,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = ADDR_WIDTH'(CFG_BOOT_ADDR)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fetch_enable_i,
  input  logic                    branch_i,
  input  logic [ADDR_WIDTH-1:0]   branch_addr_i,
  input  logic                    ready_i,
  output logic                    valid_o,
  output logic [DATA_WIDTH-1:0]   instr_o,
  output logic [ADDR_WIDTH-1:0]   pc_o,
  output logic                    mem_en_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CMP_W   = CNT_W + 1;
  localparam int unsigned ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

  fetch_state_e          state;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic [ADDR_WIDTH-1:0] pend_pc;
  logic                  pending;
  logic [ADDR_WIDTH-1:0] target_c;
  logic                  pop_c;
  logic                  push_c;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      count;
  logic [ENTRY_W-1:0]    head;

  assign target_c = branch_addr_i & ~ADDR_WIDTH'(3);
  assign valid_o  = ~fifo_empty;
  assign pop_c    = valid_o & ready_i & ~branch_i;
  assign push_c   = pending & ~branch_i & (~fifo_full | pop_c);
  assign {pc_o, instr_o} = head;
  assign mem_we_o = 1'b0;
  assign mem_be_o = '1;

  // Request only while buffer space remains after counting the in-flight word.
  always_comb begin
    mem_en_o   = 1'b0;
    mem_addr_o = fetch_addr;
    if (state == RUN) begin
      if (branch_i) begin
        mem_en_o   = 1'b1;
        mem_addr_o = target_c;
      end else begin
        mem_en_o = (CMP_W'(count) + CMP_W'(pending)) < (CMP_W'(FIFO_DEPTH) + CMP_W'(pop_c));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      fetch_addr <= BOOT_ADDR;
      pending    <= 1'b0;
      pend_pc    <= '0;
    end else begin
      state   <= fetch_enable_i ? RUN : IDLE;
      pending <= mem_en_o;
      if (mem_en_o) begin
        pend_pc    <= mem_addr_o;
        fetch_addr <= mem_addr_o + ADDR_WIDTH'(4);
      end else if (branch_i) begin
        fetch_addr <= target_c;
      end
    end
  end

  prefetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_c),
    .pop   (pop_c),
    .flush (branch_i),
    .wdata ({pend_pc, mem_rdata_i}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

endmodule

// File: tb/tb_instr_prefetch_master.sv
// Bench for instr_prefetch_master: directed vector tables plus randomized
// traffic checked against a queue-based transaction model.
module tb_instr_prefetch_master;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_enable_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [15:0] branch_addr_i = '0;
  logic        ready_i = 1'b0;
  logic        valid_o;
  logic [31:0] instr_o;
  logic [15:0] pc_o;
  logic        mem_en_o;
  logic [15:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_rdata_i = '0;

  always #5 clk = ~clk;

  instr_prefetch_master dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_enable_i (fetch_enable_i),
    .branch_i       (branch_i),
    .branch_addr_i  (branch_addr_i),
    .ready_i        (ready_i),
    .valid_o        (valid_o),
    .instr_o        (instr_o),
    .pc_o           (pc_o),
    .mem_en_o       (mem_en_o),
    .mem_addr_o     (mem_addr_o),
    .mem_we_o       (mem_we_o),
    .mem_be_o       (mem_be_o),
    .mem_rdata_i    (mem_rdata_i)
  );

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {a ^ 16'hC3A5, a};
  endfunction

  // Memory answers one cycle after a request; garbage otherwise.
  always @(posedge clk) begin
    mem_rdata_i <= mem_en_o ? mem_word(mem_addr_o) : 32'($urandom());
  end

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] instr;
  } ent_t;

  typedef struct {
    bit          fe;
    bit          rdy;
    bit          br;
    logic [15:0] ba;
    bit          ev;
    logic [15:0] epc;
    bit          een;
    logic [15:0] eaddr;
  } vec_t;

  ent_t        m_q[$];
  bit          m_run;
  bit          m_pend;
  logic [15:0] m_pend_pc;
  logic [15:0] m_fetch;
  int          n_vec = 0;
  int          n_err = 0;
  vec_t        tab[$];

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, compare against the model, then advance the model.
  task automatic do_cycle(input bit fe, input bit rdy, input bit br, input logic [15:0] ba,
                          output bit s_valid, output logic [15:0] s_pc,
                          output bit s_en, output logic [15:0] s_addr);
    bit          e_valid;
    bit          e_en;
    bit          pop;
    logic [15:0] e_addr;
    logic [15:0] tgt;
    @(negedge clk);
    fetch_enable_i = fe;
    ready_i        = rdy;
    branch_i       = br;
    branch_addr_i  = ba;
    #1;
    s_valid = valid_o;
    s_pc    = pc_o;
    s_en    = mem_en_o;
    s_addr  = mem_addr_o;
    tgt     = {ba[15:2], 2'b00};
    e_valid = (m_q.size() != 0);
    pop     = e_valid && rdy && !br;
    e_addr  = m_fetch;
    if (!m_run) begin
      e_en = 1'b0;
    end else if (br) begin
      e_en   = 1'b1;
      e_addr = tgt;
    end else begin
      e_en = (m_q.size() + int'(m_pend) - int'(pop)) < DEPTH;
    end
    check("model valid", 48'(valid_o), 48'(e_valid));
    if (e_valid) begin
      check("model pc", 48'(pc_o), 48'(m_q[0].pc));
      check("model instr", 48'(instr_o), 48'(m_q[0].instr));
    end
    check("model mem_en", 48'(mem_en_o), 48'(e_en));
    if (e_en) check("model mem_addr", 48'(mem_addr_o), 48'(e_addr));
    @(posedge clk);
    if (br) begin
      m_q.delete();
    end else begin
      if (pop) void'(m_q.pop_front());
      if (m_pend) m_q.push_back({m_pend_pc, mem_word(m_pend_pc)});
    end
    if (e_en) m_fetch = e_addr + 16'd4;
    else if (br) m_fetch = tgt;
    m_pend    = e_en;
    m_pend_pc = e_addr;
    m_run     = fe;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    fetch_enable_i = 1'b0;
    ready_i        = 1'b0;
    branch_i       = 1'b0;
    branch_addr_i  = '0;
    #1;
    check("reset valid", 48'(valid_o), 48'(0));
    check("reset mem_en", 48'(mem_en_o), 48'(0));
    check("reset instr", 48'(instr_o), 48'(0));
    check("reset pc", 48'(pc_o), 48'(0));
    m_q.delete();
    m_run   = 1'b0;
    m_pend  = 1'b0;
    m_fetch = 16'h8000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic add(input bit fe, input bit rdy, input bit br, input logic [15:0] ba,
                     input bit ev, input logic [15:0] epc, input bit een, input logic [15:0] eaddr);
    vec_t v;
    v.fe = fe; v.rdy = rdy; v.br = br; v.ba = ba;
    v.ev = ev; v.epc = epc; v.een = een; v.eaddr = eaddr;
    tab.push_back(v);
  endtask

  task automatic run_table(input string name);
    bit          s_valid;
    bit          s_en;
    logic [15:0] s_pc;
    logic [15:0] s_addr;
    foreach (tab[i]) begin
      do_cycle(tab[i].fe, tab[i].rdy, tab[i].br, tab[i].ba, s_valid, s_pc, s_en, s_addr);
      check($sformatf("%s[%0d] valid", name, i), 48'(s_valid), 48'(tab[i].ev));
      if (tab[i].ev) check($sformatf("%s[%0d] pc", name, i), 48'(s_pc), 48'(tab[i].epc));
      check($sformatf("%s[%0d] mem_en", name, i), 48'(s_en), 48'(tab[i].een));
      if (tab[i].een) check($sformatf("%s[%0d] mem_addr", name, i), 48'(s_addr), 48'(tab[i].eaddr));
    end
    tab.delete();
  endtask

  initial begin
    bit          s_valid;
    bit          s_en;
    logic [15:0] s_pc;
    logic [15:0] s_addr;
    int          rdy_bias;

    apply_reset();
    check("mem_we", 48'(mem_we_o), 48'(0));
    check("mem_be", 48'(mem_be_o), 48'(4'hF));

    // Streaming from the boot vector with the consumer always ready.
    add(1,1,0,16'h0, 0,16'h0,    0,16'h0);
    add(1,1,0,16'h0, 0,16'h0,    1,16'h8000);
    add(1,1,0,16'h0, 0,16'h0,    1,16'h8004);
    add(1,1,0,16'h0, 1,16'h8000, 1,16'h8008);
    add(1,1,0,16'h0, 1,16'h8004, 1,16'h800C);
    add(1,1,0,16'h0, 1,16'h8008, 1,16'h8010);
    run_table("stream");

    for (int blk = 0; blk < 8; blk++) begin
      rdy_bias = blk % 4;
      for (int n = 0; n < 250; n++) begin
        do_cycle($urandom_range(0, 9) != 0, $urandom_range(0, 3) < rdy_bias,
                 $urandom_range(0, 19) == 0, 16'($urandom()), s_valid, s_pc, s_en, s_addr);
      end
    end
    do_cycle(1, 1, 0, 16'h0, s_valid, s_pc, s_en, s_addr);
    do_cycle(1, 1, 0, 16'h0, s_valid, s_pc, s_en, s_addr);

    // Reset with a request in flight, then stall, fill, single pop, branch, wrap, idle branch.
    apply_reset();
    add(1,0,0,16'h0,    0,16'h0,    0,16'h0);
    add(1,0,0,16'h0,    0,16'h0,    1,16'h8000);
    add(1,0,0,16'h0,    0,16'h0,    1,16'h8004);
    add(1,0,0,16'h0,    1,16'h8000, 1,16'h8008);
    add(1,0,0,16'h0,    1,16'h8000, 1,16'h800C);
    add(1,0,0,16'h0,    1,16'h8000, 0,16'h0);
    add(1,0,0,16'h0,    1,16'h8000, 0,16'h0);
    add(1,0,0,16'h0,    1,16'h8000, 0,16'h0);
    add(1,1,0,16'h0,    1,16'h8000, 1,16'h8010);
    add(1,0,0,16'h0,    1,16'h8004, 0,16'h0);
    add(1,0,0,16'h0,    1,16'h8004, 0,16'h0);
    add(1,1,0,16'h0,    1,16'h8004, 1,16'h8014);
    add(1,0,1,16'h0103, 1,16'h8008, 1,16'h0100);
    add(1,1,0,16'h0,    0,16'h0,    1,16'h0104);
    add(1,1,0,16'h0,    1,16'h0100, 1,16'h0108);
    add(1,1,0,16'h0,    1,16'h0104, 1,16'h010C);
    add(1,1,1,16'hFFF8, 1,16'h0108, 1,16'hFFF8);
    add(1,1,0,16'h0,    0,16'h0,    1,16'hFFFC);
    add(1,1,0,16'h0,    1,16'hFFF8, 1,16'h0000);
    add(1,1,0,16'h0,    1,16'hFFFC, 1,16'h0004);
    add(1,1,0,16'h0,    1,16'h0000, 1,16'h0008);
    add(0,0,0,16'h0,    1,16'h0004, 1,16'h000C);
    add(0,0,1,16'h1234, 1,16'h0004, 0,16'h0);
    add(1,1,0,16'h0,    0,16'h0,    0,16'h0);
    add(1,1,0,16'h0,    0,16'h0,    1,16'h1234);
    add(1,1,0,16'h0,    0,16'h0,    1,16'h1238);
    add(1,1,0,16'h0,    1,16'h1234, 1,16'h123C);
    run_table("corner");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
